// File: rtl/jp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jp_pkg
// Description : Shared definitions for the joypad input conditioner:
//               poll-shadow FSM states, button bit positions inside the
//               published byte, default disconnect timeout, and a 3-input
//               majority helper used by the line filter.
// Revision    : 1.0 - initial release
// ============================================================================
package jp_pkg;

  typedef enum logic [1:0] {
    POLL_IDLE  = 2'd0,
    POLL_ARMED = 2'd1,
    POLL_SHIFT = 2'd2
  } poll_state_e;

  // Order in which a standard pad shifts its buttons out after a latch.
  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  // ~42 ms of continuous low at 25 MHz before a pad is considered unplugged.
  localparam int unsigned DEFAULT_DISCONNECT_CYCLES = 1048576;
  localparam int unsigned DEFAULT_CNT_W             = 21;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jp_port_cond.sv
`default_nettype none
// ============================================================================
// Module      : jp_port_cond
// Description : Conditioner for one joypad port: 2-flop synchroniser plus
//               3-sample majority glitch filter, pad-present detection with
//               forced-idle output while unplugged, and a shadow of the
//               CPU's latch/clock poll that publishes the 8 button states.
// Ports       : clk_in/rst_in      - clock, synchronous active-high reset
//               pin_in             - raw asynchronous pad data pin
//               latch_in, sclk_in  - CPU latch strobe and shift clock
//               data_out           - conditioned serial data to the CPU
//               connected_out      - pad-present flag
//               buttons_out        - last polled buttons, 1 = pressed
//               buttons_valid_out  - one-cycle pulse on buttons_out update
// Revision    : 1.0 - initial release
// ============================================================================
module jp_port_cond
  import jp_pkg::*;
#(
  parameter int unsigned DISCONNECT_CYCLES = DEFAULT_DISCONNECT_CYCLES,
  parameter int unsigned CNT_W             = DEFAULT_CNT_W
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       pin_in,
  input  logic       latch_in,
  input  logic       sclk_in,
  output logic       data_out,
  output logic       connected_out,
  output logic [7:0] buttons_out,
  output logic       buttons_valid_out
);

  // The counter stops one short of the timeout: the edge on which it would
  // reach DISCONNECT_CYCLES is the edge that drops the connection.
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(DISCONNECT_CYCLES - 1);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic [2:0]       h_q, h_d;
  logic             maj;
  logic             data_q, data_d;
  logic             connected_q, connected_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic             latch_q, latch_d, sclk_q, sclk_d;
  logic             latch_fall, sclk_rise;
  poll_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       buttons_q, buttons_d;
  logic             valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Line filter and connect detection
  // --------------------------------------------------------------------------
  always_comb begin
    s1_d   = pin_in;
    s2_d   = s1_q;
    h_d    = {h_q[1:0], s2_q};
    maj    = maj3(h_q);
    // An unplugged port floats to "all released" from the CPU's view.
    data_d = maj | ~connected_q;

    connected_d = connected_q;
    low_cnt_d   = low_cnt_q;
    if (maj) begin
      // A high sample always wins, even on the timeout cycle.
      connected_d = 1'b1;
      low_cnt_d   = '0;
    end else if (connected_q) begin
      if (low_cnt_q == LOW_LAST) begin
        connected_d = 1'b0;
        low_cnt_d   = '0;
      end else begin
        low_cnt_d = low_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Poll shadow FSM
  // --------------------------------------------------------------------------
  assign latch_d    = latch_in;
  assign sclk_d     = sclk_in;
  assign latch_fall = latch_q & ~latch_in;
  assign sclk_rise  = sclk_in & ~sclk_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= POLL_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (latch_in) begin
      state_d = POLL_ARMED;
    end else begin
      case (state_q)
        POLL_IDLE:  state_d = POLL_IDLE;
        POLL_ARMED: if (latch_fall) state_d = POLL_SHIFT;
        POLL_SHIFT: if (sclk_rise && idx_q == BTN_RIGHT) state_d = POLL_IDLE;
        default:    state_d = POLL_IDLE;
      endcase
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    if (latch_in) begin
      // Latch takes precedence over any coincident clock edge.
      shadow_d = '0;
      idx_d    = BTN_A;
    end else if (state_q == POLL_ARMED && latch_fall) begin
      shadow_d = '0;
      idx_d    = BTN_A;
    end else if (state_q == POLL_SHIFT && sclk_rise) begin
      // Pad lines are active-low; capture what the CPU itself sees.
      shadow_d[idx_q] = ~data_q;
      if (idx_q == BTN_RIGHT) begin
        buttons_d = shadow_d;
        valid_d   = 1'b1;
        idx_d     = BTN_A;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      h_q         <= '0;
      data_q      <= 1'b1;
      connected_q <= 1'b0;
      low_cnt_q   <= '0;
      latch_q     <= 1'b0;
      sclk_q      <= 1'b0;
      idx_q       <= '0;
      shadow_q    <= '0;
      buttons_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      h_q         <= h_d;
      data_q      <= data_d;
      connected_q <= connected_d;
      low_cnt_q   <= low_cnt_d;
      latch_q     <= latch_d;
      sclk_q      <= sclk_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      buttons_q   <= buttons_d;
      valid_q     <= valid_d;
    end
  end

  assign data_out          = data_q;
  assign connected_out     = connected_q;
  assign buttons_out       = buttons_q;
  assign buttons_valid_out = valid_q;

endmodule
`default_nettype wire

// File: rtl/jp_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : jp_input_cond
// Description : Two-port joypad input conditioner sitting between the pad
//               data pins and the rp2a03 joypad inputs. Each port is an
//               independent jp_port_cond; this level only splits and
//               concatenates the per-port vectors.
// Ports       : clk_in/rst_in     - clock, synchronous active-high reset
//               jp_data_in[1:0]   - raw pad pins (bit0 = port 1)
//               jp_latch_in       - shared latch strobe from the CPU
//               jp_clk_in[1:0]    - per-port shift clocks from the CPU
//               jp_data_out[1:0]  - conditioned serial data to the CPU
//               connected_out     - pad-present flags
//               buttons_out[15:0] - [7:0] port 1, [15:8] port 2, 1 = pressed
//               buttons_valid_out - per-port update pulse
// Revision    : 1.0 - initial release
// ============================================================================
module jp_input_cond
  import jp_pkg::*;
#(
  parameter int unsigned DISCONNECT_CYCLES = DEFAULT_DISCONNECT_CYCLES,
  parameter int unsigned CNT_W             = DEFAULT_CNT_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  jp_data_in,
  input  logic        jp_latch_in,
  input  logic [1:0]  jp_clk_in,
  output logic [1:0]  jp_data_out,
  output logic [1:0]  connected_out,
  output logic [15:0] buttons_out,
  output logic [1:0]  buttons_valid_out
);

  for (genvar p = 0; p < 2; p++) begin : g_port
    jp_port_cond #(
      .DISCONNECT_CYCLES(DISCONNECT_CYCLES),
      .CNT_W            (CNT_W)
    ) u_port (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .pin_in           (jp_data_in[p]),
      .latch_in         (jp_latch_in),
      .sclk_in          (jp_clk_in[p]),
      .data_out         (jp_data_out[p]),
      .connected_out    (connected_out[p]),
      .buttons_out      (buttons_out[p*8 +: 8]),
      .buttons_valid_out(buttons_valid_out[p])
    );
  end

endmodule
`default_nettype wire
